// File: rtl/otter_pipe_pkg.sv
// Shared types, constants and helpers for the OTTER elastic pipeline stage.
package otter_pipe_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/otter_pipe_stage.sv
// Elastic valid/ready pipeline register with optional skid entry, flush-to-bubble
// and saturating stall/flush event counters.
module otter_pipe_stage
  import otter_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 64,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (FLUSH) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = out_valid ? main_q : BUBBLE;
  end

  if (SKID) begin : g_skid
    logic in_ready_q;

    // Capture into the skid entry whenever ONE would advance to FULL; a flush in the
    // same cycle leaves stale data here, which is harmless since the state is EMPTY.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        skid_q     <= BUBBLE;
        in_ready_q <= 1'b1;
      end else begin
        if ((state_q == ONE) && in_fire && !out_fire) begin
          skid_q <= in_data;
        end
        in_ready_q <= (state_d != FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_q   = BUBBLE;
    assign in_ready = !out_valid | out_ready;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_q <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
      end
      if (FLUSH && out_valid) begin
        flush_q <= CNT_W'(sat_inc(64'(flush_q), CNT_W));
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_otter_pipe_stage.sv
// Bench for otter_pipe_stage: a SKID=1 instance and a SKID=0/CNT_W=4 instance checked
// against a queue-based model of the stage.
module tb_otter_pipe_stage;

  localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [15:0] a_stall, a_flush_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [3:0]  b_stall, b_flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: payloads currently held, oldest first, plus event counts.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int stall_a, flush_a, stall_b, flush_b;

  always #5 CLK = ~CLK;

  otter_pipe_stage #(.DATA_W(64), .SKID(1'b1), .BUBBLE(BUBBLE), .CNT_W(16)) dut_a (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .stall_cnt (a_stall),
    .flush_cnt (a_flush_cnt)
  );

  otter_pipe_stage #(.DATA_W(64), .SKID(1'b0), .BUBBLE(BUBBLE), .CNT_W(4)) dut_b (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .stall_cnt (b_stall),
    .flush_cnt (b_flush_cnt)
  );

  // Advance both models by one clock using the current inputs, then cross the edge.
  task automatic tick();
    bit ra, rb;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || b_out_ready;
    if (qa.size() > 0 && !a_out_ready) stall_a = (stall_a < 65535) ? stall_a + 1 : stall_a;
    if (a_flush) begin
      if (qa.size() > 0) flush_a = (flush_a < 65535) ? flush_a + 1 : flush_a;
      qa.delete();
    end else begin
      if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
      if (a_in_valid && ra) qa.push_back(a_in_data);
    end
    if (qb.size() > 0 && !b_out_ready) stall_b = (stall_b < 15) ? stall_b + 1 : stall_b;
    if (b_flush) begin
      if (qb.size() > 0) flush_b = (flush_b < 15) ? flush_b + 1 : flush_b;
      qb.delete();
    end else begin
      if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
      if (b_in_valid && rb) qb.push_back(b_in_data);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
  endtask

  task automatic test_reset();
    a_in_valid = 1; a_in_data = 64'hDEAD;
    tick();
    a_in_valid = 0;
    tick();
    checks++;
    if (a_stall !== 16'd1) begin
      failures++; $display("FAIL reset_pre_stall got=%0d exp=1", a_stall);
    end
    #2;
    RESET = 1;
    #1;
    qa.delete(); qb.delete();
    stall_a = 0; flush_a = 0; stall_b = 0; flush_b = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== BUBBLE) begin
      failures++; $display("FAIL reset_out got=%b/%h exp=0/%h", a_out_valid, a_out_data, BUBBLE);
    end
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", a_in_ready, b_in_ready);
    end
    checks++;
    if (a_stall !== 16'd0 || a_flush_cnt !== 16'd0 || b_stall !== 4'd0 || b_flush_cnt !== 4'd0)
    begin
      failures++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                           a_stall, a_flush_cnt, b_stall, b_flush_cnt);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== BUBBLE) begin
      failures++; $display("FAIL reset_out_b got=%b/%h exp=0/%h", b_out_valid, b_out_data, BUBBLE);
    end
    #1;
    RESET = 0;
    tick();
  endtask

  task automatic test_streaming();
    a_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1; a_in_data = 64'(i);
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 64'(i) || a_in_ready !== 1'b1) begin
        failures++; $display("FAIL stream_word%0d got=%b/%h/%b exp=1/%h/1",
                             i, a_out_valid, a_out_data, a_in_ready, 64'(i));
      end
    end
    a_in_valid = 0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== BUBBLE || a_stall !== 16'd0) begin
      failures++; $display("FAIL stream_drain got=%b/%h/%0d exp=0/%h/0",
                           a_out_valid, a_out_data, a_stall, BUBBLE);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 64'hA;
    tick();
    checks++;
    if (a_in_ready !== 1'b1 || a_out_data !== 64'hA) begin
      failures++; $display("FAIL bp_first got=%b/%h exp=1/a", a_in_ready, a_out_data);
    end
    a_in_data = 64'hB;
    tick();
    checks++;
    if (a_in_ready !== 1'b0 || a_out_data !== 64'hA) begin
      failures++; $display("FAIL bp_full got=%b/%h exp=0/a", a_in_ready, a_out_data);
    end
    a_in_valid = 0;
    tick();
    tick();
    checks++;
    if (a_stall !== 16'd3 || a_out_data !== 64'hA || a_in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_hold got=%0d/%h/%b exp=3/a/0", a_stall, a_out_data, a_in_ready);
    end
    a_out_ready = 1;
    #1;
    checks++;
    if (a_out_data !== 64'hA || a_out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release_a got=%b/%h exp=1/a", a_out_valid, a_out_data);
    end
    tick();
    checks++;
    if (a_out_data !== 64'hB || a_out_valid !== 1'b1 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_b got=%b/%h/%b exp=1/b/1",
                           a_out_valid, a_out_data, a_in_ready);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_stall !== 16'd3) begin
      failures++; $display("FAIL bp_empty got=%b/%0d exp=0/3", a_out_valid, a_stall);
    end
  endtask

  task automatic test_flush();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 64'hA;
    tick();
    a_in_data = 64'hB;
    tick();
    a_flush = 1; a_in_data = 64'hC;
    tick();
    a_flush = 0; a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== BUBBLE || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_full got=%b/%h/%b exp=0/%h/1",
                           a_out_valid, a_out_data, a_in_ready, BUBBLE);
    end
    checks++;
    if (a_flush_cnt !== 16'd1 || a_stall !== 16'(stall_a)) begin
      failures++; $display("FAIL flush_counts got=%0d/%0d exp=1/%0d", a_flush_cnt, a_stall, stall_a);
    end
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_ghost%0d got=%b/%h exp=0", i, a_out_valid, a_out_data);
      end
    end
    a_flush = 1;
    tick();
    a_flush = 0;
    checks++;
    if (a_flush_cnt !== 16'd1) begin
      failures++; $display("FAIL flush_empty_count got=%0d exp=1", a_flush_cnt);
    end
    a_in_valid = 1; a_in_data = 64'hD;
    tick();
    a_flush = 1; a_in_data = 64'hE;
    tick();
    a_flush = 0; a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b0 || a_flush_cnt !== 16'd2 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_one_drop got=%b/%0d/%b exp=0/2/1",
                           a_out_valid, a_flush_cnt, a_in_ready);
    end
  endtask

  task automatic test_skid0_ready();
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 64'h5;
    tick();
    checks++;
    if (b_out_data !== 64'h5 || b_in_ready !== 1'b0) begin
      failures++; $display("FAIL skid0_block got=%h/%b exp=5/0", b_out_data, b_in_ready);
    end
    b_in_data = 64'h6; b_out_ready = 1;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++; $display("FAIL skid0_comb_ready got=%b exp=1", b_in_ready);
    end
    tick();
    checks++;
    if (b_out_data !== 64'h6 || b_out_valid !== 1'b1) begin
      failures++; $display("FAIL skid0_replace got=%b/%h exp=1/6", b_out_valid, b_out_data);
    end
    b_in_valid = 0;
    tick();
    checks++;
    if (b_out_valid !== 1'b0 || b_stall !== 4'd0) begin
      failures++; $display("FAIL skid0_drain got=%b/%0d exp=0/0", b_out_valid, b_stall);
    end
  endtask

  task automatic test_saturation();
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 64'h7;
    tick();
    b_in_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (b_stall !== 4'(stall_b) || b_out_data !== 64'h7) begin
        failures++; $display("FAIL sat_step%0d got=%0d/%h exp=%0d/7", i, b_stall, b_out_data, stall_b);
      end
    end
    checks++;
    if (b_stall !== 4'd15) begin
      failures++; $display("FAIL sat_final got=%0d exp=15", b_stall);
    end
    b_out_ready = 1;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] exp_a, exp_b;
    for (int n = 0; n < 500; n++) begin
      a_in_valid  = $urandom_range(0, 3) != 0;
      a_in_data   = {$urandom, $urandom};
      a_out_ready = $urandom_range(0, 2) != 0;
      a_flush     = $urandom_range(0, 15) == 0;
      b_in_valid  = $urandom_range(0, 3) != 0;
      b_in_data   = {$urandom, $urandom};
      b_out_ready = $urandom_range(0, 2) != 0;
      b_flush     = $urandom_range(0, 15) == 0;
      #1;
      checks++;
      if (b_in_ready !== ((qb.size() == 0) || b_out_ready)) begin
        failures++; $display("FAIL rand_b_ready n=%0d got=%b exp=%b",
                             n, b_in_ready, (qb.size() == 0) || b_out_ready);
      end
      tick();
      exp_a = (qa.size() > 0) ? qa[0] : BUBBLE;
      exp_b = (qb.size() > 0) ? qb[0] : BUBBLE;
      checks++;
      if (a_out_valid !== (qa.size() > 0) || a_out_data !== exp_a || a_in_ready !== (qa.size() < 2))
      begin
        failures++; $display("FAIL rand_a n=%0d got=%b/%h/%b exp=%b/%h/%b", n, a_out_valid,
                             a_out_data, a_in_ready, qa.size() > 0, exp_a, qa.size() < 2);
      end
      checks++;
      if (a_stall !== 16'(stall_a) || a_flush_cnt !== 16'(flush_a)) begin
        failures++; $display("FAIL rand_a_cnt n=%0d got=%0d/%0d exp=%0d/%0d",
                             n, a_stall, a_flush_cnt, stall_a, flush_a);
      end
      checks++;
      if (b_out_valid !== (qb.size() > 0) || b_out_data !== exp_b) begin
        failures++; $display("FAIL rand_b n=%0d got=%b/%h exp=%b/%h",
                             n, b_out_valid, b_out_data, qb.size() > 0, exp_b);
      end
      checks++;
      if (b_stall !== 4'(stall_b) || b_flush_cnt !== 4'(flush_b)) begin
        failures++; $display("FAIL rand_b_cnt n=%0d got=%0d/%0d exp=%0d/%0d",
                             n, b_stall, b_flush_cnt, stall_b, flush_b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    stall_a = 0; flush_a = 0; stall_b = 0; flush_b = 0;
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0_ready();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
